// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a byte source and the UART transmitter.
//   data_in     byte to send, sampled only when data_valid && data_ready
//   data_valid  source has a byte on data_in
//   data_ready  transmitter holding register is empty
// Modports: master = byte source, slave = transmitter.
interface uart_tx_if;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, parallel byte in, serial line out, LSB first.
// A one-byte holding register lets the next byte queue during a frame so that
// consecutive frames go out with no idle gap.
//
// Parameters:
//   BAUD_RATE   line bit rate in bits/s
//   CLOCK_MHZ   clk frequency in Hz (name matches the receiver)
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    byte handshake (uart_tx_if.slave): data_in, data_valid, data_ready
//   tx     serial line, idle high, registered
//   busy   frame in progress
//   done   one-cycle pulse after the last cycle of each stop bit
// Build option:
//   UART_TX_PARITY_EN  inserts an even-parity bit after data bit 7 (8E1 frame).
module uart_tx #(
   parameter int unsigned BAUD_RATE = 9600,
   parameter int unsigned CLOCK_MHZ = 10_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   uart_tx_if.slave   bus,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CLOCKS_PER_BIT = CLOCK_MHZ / BAUD_RATE;
   localparam int unsigned CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic [7:0]       hold_reg;
   logic             hold_full;
   logic             bit_end;

   assign bus.data_ready = ~hold_full;
   assign bit_end        = (baud_cnt == BIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         hold_reg  <= '0;
         hold_full <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;

         // Acceptance and unloading never share an edge: ready is low while full.
         if (bus.data_valid && !hold_full) begin
            hold_reg  <= bus.data_in;
            hold_full <= 1'b1;
         end

         case (state)
            StIdle: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               bit_idx  <= '0;
               if (hold_full) begin
                  shift_reg <= hold_reg;
                  hold_full <= 1'b0;
                  tx        <= 1'b0;
                  busy      <= 1'b1;
                  state     <= StStart;
               end
            end

            StStart: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shift_reg[0];
                  state    <= StData;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            StData: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx    <= ^shift_reg;
                     state <= StParity;
`else
                     tx    <= 1'b1;
                     state <= StStop;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shift_reg[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

`ifdef UART_TX_PARITY_EN
            StParity: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  state    <= StStop;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif

            StStop: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  done     <= 1'b1;
                  if (hold_full) begin
                     // Queued byte starts on the very next cycle: no idle gap.
                     shift_reg <= hold_reg;
                     hold_full <= 1'b0;
                     tx        <= 1'b0;
                     state     <= StStart;
                  end else begin
                     tx    <= 1'b1;
                     busy  <= 1'b0;
                     state <= StIdle;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: begin
               state    <= StIdle;
               tx       <= 1'b1;
               busy     <= 1'b0;
               baud_cnt <= '0;
               bit_idx  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at 10 clocks per bit.
// Frames are checked on the first and last cycle of every bit, plus done timing.
module tb_uart_tx;

   localparam int unsigned BAUD   = 1_000_000;
   localparam int unsigned CLK_HZ = 10_000_000;
   localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic tx;
   logic busy;
   logic done;

   uart_tx_if bus_if ();

   uart_tx #(
      .BAUD_RATE (BAUD),
      .CLOCK_MHZ (CLK_HZ)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if),
      .tx    (tx),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Presents a byte at a negedge and returns just after the accepting posedge.
   task automatic send_byte(input logic [7:0] d, output int stall);
      @(negedge clk);
      bus_if.data_in    = d;
      bus_if.data_valid = 1'b1;
      stall = 0;
      while (!bus_if.data_ready && stall < 400) begin
         @(negedge clk);
         stall++;
      end
      check_eq($sformatf("send_%02h_not_timed_out", d), 32'(stall < 400), 1);
      @(posedge clk);
      #1;
      bus_if.data_valid = 1'b0;
      bus_if.data_in    = ~d;  // later changes must not affect the accepted byte
   endtask

   // Checks frame cycles first..NBITS*CPB-1, then the done cycle; returns tx there.
   task automatic expect_frame(input logic [7:0] d, input int first, input string tag,
                               output logic tx_end);
      logic [10:0] lv;
      int early;
      early = 0;
      lv = '1;
      lv[0] = 1'b0;
      lv[8:1] = d;
`ifdef UART_TX_PARITY_EN
      lv[9] = ^d;
`endif
      for (int k = first; k < NBITS * CPB; k++) begin
         @(negedge clk);
         if ((k % CPB) == 0 || (k % CPB) == CPB - 1)
            check_eq($sformatf("%s_bit%0d_cyc%0d", tag, k / CPB, k % CPB), tx, lv[k / CPB]);
         if (k == first) check_eq({tag, "_busy"}, busy, 1);
         if (done) early++;
      end
      check_eq({tag, "_no_early_done"}, early, 0);
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, done, 1);
      tx_end = tx;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int   st;
   int   bad;
   logic te;

   initial begin
      bus_if.data_in    = 8'h00;
      bus_if.data_valid = 1'b0;

      // Power-on reset, checked asynchronously.
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_tx", tx, 1);
      check_eq("rst_ready", bus_if.data_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("idle_tx", tx, 1);

      // Single byte 0xA5.
      send_byte(8'hA5, st);
      check_eq("a5_stall", st, 0);
      @(negedge clk);
      check_eq("a5_latency_tx", tx, 1);
      check_eq("a5_ready_held", bus_if.data_ready, 0);
      expect_frame(8'hA5, 0, "a5", te);
      check_eq("a5_stop_to_idle", te, 1);
      @(negedge clk);
      check_eq("a5_done_one_cycle", done, 0);
      check_eq("a5_idle_busy", busy, 0);

      // Asynchronous reset while tx is driving a 0 data bit.
      send_byte(8'h00, st);
      repeat (25) @(negedge clk);
      check_eq("async_pre_tx", tx, 0);
      rst_n = 1'b0;
      #1;
      check_eq("async_tx", tx, 1);
      check_eq("async_busy", busy, 0);
      check_eq("async_ready", bus_if.data_ready, 1);
      check_eq("async_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back 0x00, 0xFF, then a stalled 0x5A.
      send_byte(8'h00, st);
      fork
         begin
            @(negedge clk);
            check_eq("b2b_latency_tx", tx, 1);
            expect_frame(8'h00, 0, "b2b00", te);
            check_eq("b2b_gap_00_ff", te, 0);
            expect_frame(8'hFF, 1, "b2bff", te);
            check_eq("b2b_gap_ff_5a", te, 0);
            expect_frame(8'h5A, 1, "b2b5a", te);
            check_eq("b2b_end_idle_tx", te, 1);
            @(negedge clk);
            check_eq("b2b_done_one_cycle", done, 0);
            check_eq("b2b_idle_busy", busy, 0);
         end
         begin
            int s1;
            int s2;
            send_byte(8'hFF, s1);
            check_eq("b2b_ff_stall", s1, 1);
            send_byte(8'h5A, s2);
            check_eq("b2b_5a_stall", s2, 99);
         end
      join

      // Reset mid-frame during data bit 3 of 0x3C, with 0x99 queued.
      send_byte(8'h3C, st);
      send_byte(8'h99, st);
      check_eq("held_stall", st, 1);
      repeat (44) @(negedge clk);
      check_eq("midrst_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_tx", tx, 1);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_ready", bus_if.data_ready, 1);
      check_eq("midrst_done", done, 0);
      bad = 0;
      repeat (2) begin
         @(negedge clk);
         if (done !== 1'b0) bad++;
      end
      rst_n = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      check_eq("midrst_quiet_after", bad, 0);

      send_byte(8'h81, st);
      @(negedge clk);
      expect_frame(8'h81, 0, "x81", te);
      check_eq("x81_end_tx", te, 1);

      // Parity-sensitive bytes (frame length follows the build option).
      send_byte(8'h07, st);
      @(negedge clk);
      expect_frame(8'h07, 0, "x07", te);
      check_eq("x07_end_tx", te, 1);
      send_byte(8'h03, st);
      @(negedge clk);
      expect_frame(8'h03, 0, "x03", te);
      check_eq("x03_end_tx", te, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
